// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access size encodings, FSM state
// type, size-to-byte-mask constants and small lane helpers.
package mem_pkg;

  // Access size, taken from funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return MASK_B;
      SZ_H:    return MASK_H;
      SZ_W:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  // An access is misaligned when the byte offset is not a multiple of its size
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return offset[0];
      SZ_W:    return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load lane alignment: shifts the addressed bytes of a doubleword down to
// bit 0, truncates to the access size and sign/zero extends to 64 bits.
// Ports:
//   rdata       - raw doubleword from data memory
//   offset      - byte offset of the access within the doubleword
//   size        - access size (SZ_B/H/W/D)
//   is_unsigned - 1 = zero-extend, 0 = sign-extend
//   data        - extended load value
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (size)
      SZ_B:    data = is_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SZ_H:    data = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    data = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM pipeline stage plus MEM/WB register. Issues loads/stores on a req/ack
// data-memory port, stalls the upstream pipeline while an access is in
// flight, aborts an access after TIMEOUT_CYCLES busy cycles (0 = never),
// resolves beq/bne for PC select and registers writeback data.
// Ports:
//   clk, reset_n            - clock, synchronous active-low reset
//   *_S                     - EX/MEM register outputs (controls, result, store data, branch)
//   dmem_*                  - data-memory request/response port
//   stall_mem               - hold PC/IF/ID/EX/EX_MEM this cycle
//   PCSrc, Branch_Target    - branch redirect
//   misalign, bus_error     - one-cycle error pulses
//   *_W                     - MEM/WB register outputs
//
// state | meaning
// IDLE  | no access in flight; ALU results and bubbles flow to MEM/WB
// BUSY  | request outstanding; waiting for dmem_ack or timeout
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RegWrite_S,
  input  logic        MemtoReg_S,
  input  logic        MemRead_S,
  input  logic        MemWrite_S,
  input  logic        Branch_S,
  input  logic        ZERO_S,
  input  logic [63:0] Result_S,
  input  logic [63:0] Write_Data_Mem_S,
  input  logic [63:0] Branch_Address_S,
  input  logic [3:0]  Funct_S,
  input  logic [4:0]  RD_S,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        stall_mem,
  output logic        PCSrc,
  output logic [63:0] Branch_Target,
  output logic        misalign,
  output logic        bus_error,
  output logic        RegWrite_W,
  output logic        MemtoReg_W,
  output logic [63:0] Read_Data_W,
  output logic [63:0] Result_W,
  output logic [4:0]  RD_W
);

  localparam int              TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;
  logic             misal;
  logic             timeout_hit;
  logic [1:0]       size;
  logic [2:0]       offset;
  logic [63:0]      load_data;
  logic             unused_funct7;

  assign mem_op        = MemRead_S | MemWrite_S;
  assign size          = Funct_S[1:0];
  assign offset        = Result_S[2:0];
  assign misal         = is_misaligned(size, offset);
  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  assign unused_funct7 = Funct_S[3];

  // beq takes on ZERO, bne on !ZERO; selected by funct3[0]
  assign PCSrc         = Branch_S & (Funct_S[0] ? ~ZERO_S : ZERO_S);
  assign Branch_Target = Branch_Address_S;

  // Ack beats timeout, so the stall only drops on completion or abort
  always_comb begin
    stall_mem = 1'b0;
    case (state)
      IDLE:    stall_mem = mem_op & ~misal;
      BUSY:    stall_mem = ~dmem_ack & ~timeout_hit;
      default: stall_mem = 1'b0;
    endcase
  end

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .offset      (offset),
    .size        (size),
    .is_unsigned (Funct_S[2]),
    .data        (load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_be     <= '0;
      misalign    <= 1'b0;
      bus_error   <= 1'b0;
      RegWrite_W  <= 1'b0;
      MemtoReg_W  <= 1'b0;
      Read_Data_W <= '0;
      Result_W    <= '0;
      RD_W        <= '0;
    end else begin
      // MEM/WB defaults to a bubble; only pass-through and completion override it
      misalign    <= 1'b0;
      bus_error   <= 1'b0;
      RegWrite_W  <= 1'b0;
      MemtoReg_W  <= 1'b0;
      Read_Data_W <= '0;
      Result_W    <= '0;
      RD_W        <= '0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (misal) begin
              misalign <= 1'b1;
            end else begin
              state      <= BUSY;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite_S;
              dmem_addr  <= {Result_S[63:3], 3'b000};
              dmem_wdata <= Write_Data_Mem_S << {offset, 3'b000};
              dmem_be    <= size_mask(size) << offset;
            end
          end else begin
            RegWrite_W <= RegWrite_S;
            MemtoReg_W <= MemtoReg_S;
            Result_W   <= Result_S;
            RD_W       <= RD_S;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            RegWrite_W  <= RegWrite_S;
            MemtoReg_W  <= MemtoReg_S;
            Read_Data_W <= load_data;
            Result_W    <= Result_S;
            RD_W        <= RD_S;
            state       <= IDLE;
            cnt         <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_be     <= '0;
          end else if (timeout_hit) begin
            bus_error <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            dmem_be   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline MEM stage plus MEM/WB register. Consumes the EX/MEM register outputs and performs load/store through a req/ack data-memory port, stalling the pipeline while an access is outstanding.
- Resolves branches for PC select.
- Registers writeback data for the WB stage and register-file forwarding.

Parameters:
- TIMEOUT_CYCLES, 255: max BUSY cycles before the access aborts; 0 disables the timeout.
- CNT_W, 16: width of the timeout counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- RegWrite_S, MemtoReg_S, MemRead_S, MemWrite_S, Branch_S, ZERO_S  in  1 each  EX/MEM controls
- Result_S  in  64  ALU result / memory address
- Write_Data_Mem_S  in  64  store data
- Branch_Address_S  in  64  branch target
- Funct_S  in  4  {funct7[5], funct3}
- RD_S  in  5  destination register
- dmem_req  out  1  access request (registered)
- dmem_we  out  1  1 = store
- dmem_addr  out  64  doubleword-aligned address (Result_S with [2:0] forced to 0)
- dmem_wdata  out  64  lane-shifted store data
- dmem_be  out  8  byte enables
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  64  load data, valid with ack
- stall_mem  out  1  hold PC/IF/ID/EX/EX_MEM (combinational)
- PCSrc  out  1  take branch (combinational)
- Branch_Target  out  64  equals Branch_Address_S
- misalign  out  1  registered one-cycle pulse
- bus_error  out  1  registered one-cycle pulse on timeout
- RegWrite_W, MemtoReg_W  out  1 each  MEM/WB controls
- Read_Data_W, Result_W  out  64  load data, ALU result
- RD_W  out  5  destination register

Behaviour:
- Reset (reset_n=0 at posedge):
  - FSM goes to IDLE; counter = 0.
  - dmem_req, dmem_we, dmem_be, misalign, bus_error all 0.
  - All *_W outputs 0.
  - Reset mid-BUSY abandons the access: dmem_req is 0 in the next cycle, and a late ack is ignored.
- mem_op = MemRead_S | MemWrite_S.
- Size from Funct_S[1:0]: 00 byte, 01 half, 10 word, 11 double.
  - Funct_S[2]=1 means unsigned load (lbu/lhu/lwu).
  - Funct_S[3] is ignored for memory ops.
- Misaligned when the address is not a multiple of the size (half: a[0]; word: a[1:0]; double: a[2:0]).
- Store lanes:
  - dmem_be = size_mask << a[2:0], with size_mask one of 01, 03, 0F, FF.
  - dmem_wdata = Write_Data_Mem_S << (8*a[2:0]).
- Load data:
  - Take dmem_rdata >> (8*a[2:0]) and truncate to size.
  - Sign- or zero-extend to 64 bits per Funct_S[2].
  - All lane and extension values are captured from inputs held stable by the stall.
- FSM state IDLE:
  - mem_op & !misaligned:
    - stall_mem=1.
    - Next state BUSY; dmem_req/we/addr/wdata/be are registered at this edge.
    - MEM/WB loads a bubble (all *_W = 0).
  - mem_op & misaligned:
    - No request; stall_mem=0.
    - misalign pulses next cycle.
    - MEM/WB loads a bubble.
  - No mem_op:
    - stall_mem=0.
    - MEM/WB loads RegWrite_S, MemtoReg_S, Result_S, RD_S; Read_Data_W=0.
  - dmem_ack in IDLE is ignored.
- FSM state BUSY:
  - dmem_req held at 1 with constant address/data; counter increments each cycle.
  - stall_mem = !dmem_ack.
  - dmem_ack=1:
    - MEM/WB captures controls, RD, Result and extended load data (store: RegWrite_W passes from RegWrite_S, normally 0).
    - dmem_req drops next cycle; next state IDLE; counter cleared.
  - counter == TIMEOUT_CYCLES-1 without ack (when TIMEOUT_CYCLES≠0):
    - bus_error pulses; stall_mem=0 that cycle.
    - MEM/WB loads a bubble; next state IDLE.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no bus_error.
- Latency: access completes in minimum 2 cycles (IDLE edge plus BUSY ack cycle); non-memory ops take 1 cycle.
- Branch resolution (combinational, independent of FSM):
  - Branch_S & taken drives PCSrc=1.
  - taken = ZERO_S when Funct_S[0]=0 (beq), !ZERO_S when Funct_S[0]=1 (bne).
  - Branches never have mem_op, so PCSrc and stall_mem are never simultaneously 1.

Decomposition:
- Shared package mem_pkg holds:
  - Size encodings SZ_B/H/W/D.
  - FSM state typedef {IDLE, BUSY}.
  - Size-to-mask constants.
- One sub-module, load_align (combinational): rdata, a[2:0], size, unsigned in → 64-bit extended value out.
  - The same lane logic, mirrored, produces store be/wdata inline.

Test Plan:
- ld, Result_S=0x1000, ack on the first BUSY cycle with rdata=0x1122334455667788:
  - stall_mem high for 1 cycle.
  - Read_Data_W=0x1122334455667788, dmem_be=FF.
- lb at 0x1003, rdata byte3=0x80:
  - Read_Data_W=0xFFFFFFFFFFFFFF80, and with lbu 0x80.
  - lhu at 0x1006 with rdata[63:48]=0xBEEF → 0xBEEF.
- sw at 0x2004, data 0xDEADBEEF:
  - dmem_be=F0, dmem_wdata=0xDEADBEEF00000000, dmem_we=1.
  - After ack, RegWrite_W=0.
- lw at 0x1002:
  - No dmem_req, misalign pulses 1 cycle, bubble written, stall_mem never asserted.
- ld with no ack, TIMEOUT_CYCLES=4:
  - stall_mem high for 4 cycles, bus_error pulses.
  - Return to IDLE; a later spurious ack is ignored.
- Branch_S=1, Funct_S=0001, ZERO_S=0:
  - PCSrc=1, Branch_Target=Branch_Address_S.
- Load in BUSY, reset_n=0 for 1 cycle, ack next cycle:
  - All outputs 0, no capture.
